// File: rtl/frame_rect_painter.sv
// rtl/frame_rect_painter.sv - rectangle fill / full-frame clear writer for the frame buffer
//
// Accepts one rectangle-fill (start) or full-frame clear (clear) command at a
// time and walks the covered pixels in raster order. It issues one registered
// write per cycle on the frame buffer write port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, clear      one-cycle command strobes (clear wins), sampled in IDLE only
//   x0, y0, x1, y1    inclusive rectangle corners, clamped to the frame
//   color             fill colour
//   busy              high in FILL and DONE
//   done              one-cycle completion pulse
//   wr, addr, di      frame buffer write enable, address (y*W + x), data
module frame_rect_painter #(
    parameter int W  = 120,
    parameter int H  = 60,
    parameter int AW = 16,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clear,
    input  logic [7:0]    x0,
    input  logic [7:0]    y0,
    input  logic [7:0]    x1,
    input  logic [7:0]    y1,
    input  logic [CW-1:0] color,
    output logic          busy,
    output logic          done,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] di
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]    XMAX = 8'(W - 1);
    localparam logic [7:0]    YMAX = 8'(H - 1);
    localparam logic [AW-1:0] W_A  = AW'(W);

    state_t        state_q;
    logic [7:0]    x_q, y_q, x0_q, x1_q, y1_q;
    logic [AW-1:0] row_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] di_q;
    logic          wr_q, done_q, busy_q;

    // Clamped command corners, valid only at the accepting edge.
    logic [7:0]    cx0_d, cx1_d, cy0_d, cy1_d;
    logic [AW-1:0] row0_d;
    logic          empty_d;

    always_comb begin
        cx0_d   = clear ? 8'd0 : ((x0 > XMAX) ? XMAX : x0);
        cx1_d   = clear ? XMAX : ((x1 > XMAX) ? XMAX : x1);
        cy0_d   = clear ? 8'd0 : ((y0 > YMAX) ? YMAX : y0);
        cy1_d   = clear ? YMAX : ((y1 > YMAX) ? YMAX : y1);
        // Only the starting row needs a product; it is by a constant, and
        // later rows step the running base by W instead.
        row0_d  = AW'(cy0_d) * W_A;
        empty_d = (cx0_d > cx1_d) || (cy0_d > cy1_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (clear || start) begin
                        x_q    <= cx0_d;
                        y_q    <= cy0_d;
                        x0_q   <= cx0_d;
                        x1_q   <= cx1_d;
                        y1_q   <= cy1_d;
                        row_q  <= row0_d;
                        di_q   <= color;
                        busy_q <= 1'b1;
                        if (empty_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // First write goes out on the accepting edge.
                            state_q <= FILL;
                            wr_q    <= 1'b1;
                            addr_q  <= row0_d + AW'(cx0_d);
                        end
                    end
                end
                FILL: begin
                    if (x_q == x1_q && y_q == y1_q) begin
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (x_q < x1_q) begin
                        x_q    <= x_q + 8'd1;
                        addr_q <= row_q + AW'(x_q + 8'd1);
                    end else begin
                        x_q    <= x0_q;
                        y_q    <= y_q + 8'd1;
                        row_q  <= row_q + W_A;
                        addr_q <= row_q + W_A + AW'(x0_q);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign wr   = wr_q;
    assign addr = addr_q;
    assign di   = di_q;

endmodule

// File: doc/frame_rect_painter.md
Name: frame_rect_painter

Overview:
- Upstream write-side stage for the 120x60, 3-bit-per-pixel frame buffer.
- Accepts one rectangle-fill or full-screen-clear command at a time.
- Walks the covered pixels in raster order, issuing one registered write per cycle on the frame buffer's write port (wr/addr/di).
- Game logic draws the bottle, platforms and background through it instead of driving the buffer directly.

Parameters:
- W, 120, frame width in pixels.
- H, 60, frame height in pixels.
- AW, 16, frame buffer address width.
- CW, 3, pixel colour width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe, rectangle fill; sampled only in IDLE.
- clear  in  1  one-cycle command strobe, fill whole frame with color; sampled only in IDLE; has priority over start.
- x0  in  8  rectangle left column, inclusive.
- y0  in  8  rectangle top row, inclusive.
- x1  in  8  rectangle right column, inclusive.
- y1  in  8  rectangle bottom row, inclusive.
- color  in  CW  fill colour.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- wr  out  1  frame buffer write enable.
- addr  out  AW  frame buffer write address, y*W + x.
- di  out  CW  frame buffer write data.

Behaviour:
- Reset values: busy=0, done=0, wr=0, addr=0, di=0; state=IDLE. Reset applies at any time.
- Reset mid-FILL: wr=0 after that edge; no further writes; no done pulse.
- States: IDLE, FILL, DONE.
- Command latch, in IDLE on an edge with clear=1 or start=1:
  - Latch the command and color.
  - clear uses x0=0, y0=0, x1=W-1, y1=H-1.
  - Clamp x0 and x1 to W-1, and y0 and y1 to H-1, before use.
- Empty rectangle (clamped x0>x1 or y0>y1): go to DONE, no write issued.
- Non-empty rectangle: go to FILL. The same edge registers wr=1, addr=y0*W+x0, di=color. The first write is therefore visible the cycle after the strobe.
- FILL, each subsequent edge:
  - If x<x1: x+1.
  - Else: x returns to x0 and y+1, using a running row base incremented by W (no multiplier).
  - addr = row_base + x, registered; wr stays 1; di constant.
- Write count: exactly (x1-x0+1)*(y1-y0+1) consecutive cycles with wr=1, no gaps.
- After the last pixel (x==x1, y==y1): next edge sets wr=0, done=1, state DONE.
- DONE: next edge sets done=0, state IDLE. busy is high in FILL and DONE.
- start/clear while busy are ignored, not queued. A new command may be accepted on the first IDLE cycle after DONE.
- Address arithmetic is AW bits wide; maximum address W*H-1=7199; no wrap-around.
- Inputs other than start/clear are only sampled at the accepting edge. Changes during FILL have no effect.

Test Plan:
- Reset check: assert rst 2 cycles -> wr=0, done=0, busy=0, addr=0. Then rst while FILL at pixel 10 of a 240-pixel rect -> wr=0 the next cycle, no done pulse, busy=0.
- Single pixel: start with (5,3)-(5,3), color=4 -> exactly one wr cycle, addr=365, di=4, the cycle after start. done=1 the following cycle, then busy=0.
- Two-row strip: (0,0)-(119,1), color=2 -> 240 consecutive writes, addr 0..239 contiguous. done one cycle after addr 239.
- Clear with color=0 -> 7200 consecutive writes, addr 0..7199, all di=0. done after 7199. Pulse start at write 100 -> ignored, write count unchanged.
- Clamp and sub-rect: (118,58)-(200,90), color=7 -> writes at addr 7078, 7079, 7198, 7199 only, then done. Also (10,5)-(12,6) -> addr 610, 611, 612, 730, 731, 732.
- Empty rect: x0=20, x1=10 -> no wr; done=1 the cycle after start; busy high for exactly that one cycle.
